// File: rtl/fib_lookup_walker.sv
// fib_lookup_walker: walks the FIB trie one level per name component, issuing
// one lookup per component to the selected level memory and reporting the
// deepest match (hit flag, matched depth and final next pointer).
module fib_lookup_walker #(
    parameter int WORD_SIZE     = 16,
    parameter int POINTER_SIZE  = 16,
    parameter int NUM_LEVELS    = 4,
    parameter int LEVEL_LATENCY = 1,
    parameter int ROOT_ADDRESS  = 0
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [WORD_SIZE-1:0]              name_word_in,
    input  logic                              name_valid_in,
    input  logic                              name_last_in,
    output logic                              name_ready_out,
    output logic                              level_req_out,
    output logic [$clog2(NUM_LEVELS)-1:0]     level_sel_out,
    output logic [POINTER_SIZE-1:0]           address_out,
    output logic [WORD_SIZE-1:0]              lookup_cont_out,
    input  logic [POINTER_SIZE-1:0]           next_pointer_in,
    input  logic                              is_match_in,
    input  logic                              no_child_in,
    output logic                              result_valid_out,
    input  logic                              result_ready_in,
    output logic                              result_hit_out,
    output logic [$clog2(NUM_LEVELS+1)-1:0]   result_depth_out,
    output logic [POINTER_SIZE-1:0]           result_pointer_out,
    output logic                              busy_out
);

    localparam int LVL_W = $clog2(NUM_LEVELS);
    localparam int DEP_W = $clog2(NUM_LEVELS + 1);
    localparam int CNT_W = $clog2(LEVEL_LATENCY + 1);

    typedef enum logic [2:0] {
        FETCH,
        ISSUE,
        WAIT,
        DRAIN,
        RESULT
    } state_t;

    state_t                  state;
    state_t                  state_nxt;
    logic [LVL_W-1:0]        level;
    logic [POINTER_SIZE-1:0] pointer;
    logic [DEP_W-1:0]        depth;
    logic [WORD_SIZE-1:0]    word;
    logic                    last;
    logic                    hit;
    logic [CNT_W-1:0]        wait_cnt;

    logic                    sample;
    logic [DEP_W-1:0]        depth_inc;
    logic                    at_limit;

    // The level response is taken on the edge that ends the final WAIT cycle.
    assign sample    = (state == WAIT) && (wait_cnt == CNT_W'(1));
    assign depth_inc = depth + DEP_W'(1);
    assign at_limit  = (depth_inc == DEP_W'(NUM_LEVELS));

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= FETCH;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode and output drive; ready is held low while in reset.
    always_comb begin
        state_nxt          = state;
        name_ready_out     = 1'b0;
        level_req_out      = 1'b0;
        result_valid_out   = 1'b0;
        result_hit_out     = 1'b0;
        result_depth_out   = '0;
        result_pointer_out = '0;
        busy_out           = 1'b1;
        level_sel_out      = level;
        address_out        = pointer;
        lookup_cont_out    = word;
        case (state)
            FETCH: begin
                name_ready_out = rst_n;
                busy_out       = (level != '0);
                if (name_valid_in) begin
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                level_req_out = 1'b1;
                state_nxt     = WAIT;
            end
            WAIT: begin
                if (sample) begin
                    if (is_match_in) begin
                        if (last) begin
                            state_nxt = RESULT;
                        end else if (no_child_in || at_limit) begin
                            state_nxt = DRAIN;
                        end else begin
                            state_nxt = FETCH;
                        end
                    end else begin
                        state_nxt = last ? RESULT : DRAIN;
                    end
                end
            end
            DRAIN: begin
                name_ready_out = rst_n;
                if (name_valid_in && name_last_in) begin
                    state_nxt = RESULT;
                end
            end
            RESULT: begin
                result_valid_out   = 1'b1;
                result_hit_out     = hit;
                result_depth_out   = depth;
                result_pointer_out = pointer;
                if (result_ready_in) begin
                    state_nxt = FETCH;
                end
            end
            default: begin
                state_nxt = FETCH;
            end
        endcase
    end

    // Walk context: latched component, level/pointer/depth and match outcome.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level    <= '0;
            pointer  <= POINTER_SIZE'(ROOT_ADDRESS);
            depth    <= '0;
            word     <= '0;
            last     <= 1'b0;
            hit      <= 1'b0;
            wait_cnt <= '0;
        end else begin
            case (state)
                FETCH: begin
                    if (name_valid_in) begin
                        word <= name_word_in;
                        last <= name_last_in;
                    end
                end
                ISSUE: begin
                    wait_cnt <= CNT_W'(LEVEL_LATENCY);
                end
                WAIT: begin
                    wait_cnt <= wait_cnt - CNT_W'(1);
                    if (sample) begin
                        if (is_match_in) begin
                            depth   <= depth_inc;
                            pointer <= next_pointer_in;
                            hit     <= last;
                            if (!last && !no_child_in && !at_limit) begin
                                level <= level + LVL_W'(1);
                            end
                        end else begin
                            hit <= 1'b0;
                        end
                    end
                end
                RESULT: begin
                    if (result_ready_in) begin
                        level   <= '0;
                        pointer <= POINTER_SIZE'(ROOT_ADDRESS);
                        depth   <= '0;
                        hit     <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fib_lookup_walker.sv
// Directed bench for fib_lookup_walker: a small trie table answers level
// requests; names are pushed in and requests/results compared to hand values.
module tb_fib_lookup_walker;

    logic        clk;
    logic        rst_n;
    logic [15:0] name_word_in;
    logic        name_valid_in;
    logic        name_last_in;
    logic        name_ready_out;
    logic        level_req_out;
    logic [1:0]  level_sel_out;
    logic [15:0] address_out;
    logic [15:0] lookup_cont_out;
    logic [15:0] next_pointer_in;
    logic        is_match_in;
    logic        no_child_in;
    logic        result_valid_out;
    logic        result_ready_in;
    logic        result_hit_out;
    logic [2:0]  result_depth_out;
    logic [15:0] result_pointer_out;
    logic        busy_out;

    fib_lookup_walker #(
        .WORD_SIZE     (16),
        .POINTER_SIZE  (16),
        .NUM_LEVELS    (4),
        .LEVEL_LATENCY (1),
        .ROOT_ADDRESS  (0)
    ) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .name_word_in       (name_word_in),
        .name_valid_in      (name_valid_in),
        .name_last_in       (name_last_in),
        .name_ready_out     (name_ready_out),
        .level_req_out      (level_req_out),
        .level_sel_out      (level_sel_out),
        .address_out        (address_out),
        .lookup_cont_out    (lookup_cont_out),
        .next_pointer_in    (next_pointer_in),
        .is_match_in        (is_match_in),
        .no_child_in        (no_child_in),
        .result_valid_out   (result_valid_out),
        .result_ready_in    (result_ready_in),
        .result_hit_out     (result_hit_out),
        .result_depth_out   (result_depth_out),
        .result_pointer_out (result_pointer_out),
        .busy_out           (busy_out)
    );

    typedef struct {
        int          sel;
        logic [15:0] addr;
        logic [15:0] cont;
        logic [15:0] ptr;
        bit          nochild;
    } entry_t;

    entry_t      tbl[$];
    logic [15:0] name_q[$];
    int          exp_sel[$];
    logic [15:0] exp_addr[$];
    logic [15:0] exp_cont[$];
    int          got_sel[$];
    logic [15:0] got_addr[$];
    logic [15:0] got_cont[$];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int hs_cyc   = 0;
    int res_cyc  = 0;
    bit prev_req = 1'b0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic void add_entry(input int s, input logic [15:0] a, input logic [15:0] c,
                                      input logic [15:0] p, input bit nc);
        entry_t e;
        e.sel = s; e.addr = a; e.cont = c; e.ptr = p; e.nochild = nc;
        tbl.push_back(e);
    endfunction

    // Level memory model: records each request and answers from the table.
    // A miss also raises no_child_in, which the walker must ignore.
    initial begin
        is_match_in     = 1'b0;
        no_child_in     = 1'b0;
        next_pointer_in = 16'h0;
        forever begin
            @(negedge clk);
            if (level_req_out) begin
                check_eq("req_gap", 32'(prev_req), 32'd0);
                got_sel.push_back(int'(level_sel_out));
                got_addr.push_back(address_out);
                got_cont.push_back(lookup_cont_out);
                is_match_in     = 1'b0;
                no_child_in     = 1'b1;
                next_pointer_in = 16'hDEAD;
                foreach (tbl[i]) begin
                    if (tbl[i].sel == int'(level_sel_out) && tbl[i].addr == address_out &&
                        tbl[i].cont == lookup_cont_out) begin
                        is_match_in     = 1'b1;
                        no_child_in     = tbl[i].nochild;
                        next_pointer_in = tbl[i].ptr;
                    end
                end
            end
            prev_req = level_req_out;
        end
    end

    // Called just after a rising edge; returns just after the handshake edge.
    task automatic send_word(input logic [15:0] w, input bit lst);
        int n = 0;
        name_word_in  = w;
        name_last_in  = lst;
        name_valid_in = 1'b1;
        while (!name_ready_out && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (!name_ready_out) check_eq("send_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        hs_cyc        = cyc;
        name_valid_in = 1'b0;
        name_last_in  = 1'b0;
    endtask

    task automatic wait_result(input string tag);
        int n = 0;
        while (!result_valid_out && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (!result_valid_out) check_eq({tag, "_timeout"}, 32'd0, 32'd1);
        res_cyc = cyc;
    endtask

    task automatic run_name(input string tag, input bit exp_hit, input int exp_depth,
                            input logic [15:0] exp_ptr, input bit consume);
        int first_hs = 0;
        got_sel.delete(); got_addr.delete(); got_cont.delete();
        foreach (name_q[i]) begin
            send_word(name_q[i], i == name_q.size() - 1);
            if (i == 0) first_hs = hs_cyc;
        end
        wait_result(tag);
        hs_cyc = first_hs;
        check_eq({tag, "_hit"},   32'(result_hit_out),     32'(exp_hit));
        check_eq({tag, "_depth"}, 32'(result_depth_out),   32'(exp_depth));
        check_eq({tag, "_ptr"},   32'(result_pointer_out), 32'(exp_ptr));
        check_eq({tag, "_nreq"},  32'(got_sel.size()),     32'(exp_sel.size()));
        foreach (exp_sel[i]) begin
            if (i < got_sel.size()) begin
                check_eq({tag, "_sel"},  32'(got_sel[i]),  32'(exp_sel[i]));
                check_eq({tag, "_addr"}, 32'(got_addr[i]), 32'(exp_addr[i]));
                check_eq({tag, "_cont"}, 32'(got_cont[i]), 32'(exp_cont[i]));
            end
        end
        if (consume) begin
            @(posedge clk); #1;
            check_eq({tag, "_done_valid"}, 32'(result_valid_out), 32'd0);
            check_eq({tag, "_done_busy"},  32'(busy_out),         32'd0);
            check_eq({tag, "_done_ready"}, 32'(name_ready_out),   32'd1);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_ready"}, 32'(name_ready_out),     32'd0);
        check_eq({tag, "_req"},   32'(level_req_out),      32'd0);
        check_eq({tag, "_sel"},   32'(level_sel_out),      32'd0);
        check_eq({tag, "_addr"},  32'(address_out),        32'd0);
        check_eq({tag, "_cont"},  32'(lookup_cont_out),    32'd0);
        check_eq({tag, "_rv"},    32'(result_valid_out),   32'd0);
        check_eq({tag, "_rhit"},  32'(result_hit_out),     32'd0);
        check_eq({tag, "_rdep"},  32'(result_depth_out),   32'd0);
        check_eq({tag, "_rptr"},  32'(result_pointer_out), 32'd0);
        check_eq({tag, "_busy"},  32'(busy_out),           32'd0);
    endtask

    task automatic load_two_level_trie();
        tbl.delete();
        add_entry(0, 16'd0, 16'h7B7D, 16'd1, 1'b0);
        add_entry(1, 16'd1, 16'h2121, 16'd5, 1'b0);
    endtask

    initial begin
        name_word_in    = 16'h0;
        name_valid_in   = 1'b0;
        name_last_in    = 1'b0;
        result_ready_in = 1'b1;
        rst_n           = 1'b1;

        // Reset asserted between edges: outputs must settle without a clock.
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("rst");
        #10 rst_n = 1'b1;
        #1;
        check_eq("rst_rel_ready", 32'(name_ready_out), 32'd1);
        check_eq("rst_rel_busy",  32'(busy_out),       32'd0);
        @(posedge clk); #1;

        // Two-word hit; the result appears 6 cycles after the handshake cycle
        // began, i.e. 5 rising edges after the handshake edge.
        load_two_level_trie();
        name_q   = '{16'h7B7D, 16'h2121};
        exp_sel  = '{0, 1};
        exp_addr = '{16'd0, 16'd1};
        exp_cont = '{16'h7B7D, 16'h2121};
        run_name("hit2", 1'b1, 2, 16'd5, 1'b1);
        check_eq("hit2_latency", 32'(res_cyc - hs_cyc), 32'd5);

        // Mismatch at level 1; the third word is drained.
        name_q   = '{16'h7B7D, 16'h5C58, 16'h6C00};
        exp_sel  = '{0, 1};
        exp_addr = '{16'd0, 16'd1};
        exp_cont = '{16'h7B7D, 16'h5C58};
        run_name("miss1", 1'b0, 1, 16'd1, 1'b1);

        // Single-word miss at level 0: depth 0 reports the root address.
        name_q   = '{16'h4142};
        exp_sel  = '{0};
        exp_addr = '{16'd0};
        exp_cont = '{16'h4142};
        run_name("miss0", 1'b0, 0, 16'd0, 1'b1);

        // Leaf at level 0 on a 2-word name: second word drained.
        tbl.delete();
        add_entry(0, 16'd0, 16'h1234, 16'h00A7, 1'b1);
        name_q   = '{16'h1234, 16'h5678};
        exp_sel  = '{0};
        exp_addr = '{16'd0};
        exp_cont = '{16'h1234};
        run_name("nochild", 1'b0, 1, 16'h00A7, 1'b1);

        // Depth limit: four matches exhaust the levels; fifth word drained.
        tbl.delete();
        add_entry(0, 16'd0, 16'h0A0A, 16'd2, 1'b0);
        add_entry(1, 16'd2, 16'h0B0B, 16'd3, 1'b0);
        add_entry(2, 16'd3, 16'h0C0C, 16'd4, 1'b0);
        add_entry(3, 16'd4, 16'h0D0D, 16'd9, 1'b0);
        name_q   = '{16'h0A0A, 16'h0B0B, 16'h0C0C, 16'h0D0D, 16'h0E0E};
        exp_sel  = '{0, 1, 2, 3};
        exp_addr = '{16'd0, 16'd2, 16'd3, 16'd4};
        exp_cont = '{16'h0A0A, 16'h0B0B, 16'h0C0C, 16'h0D0D};
        run_name("limit", 1'b0, 4, 16'd9, 1'b1);

        // Backpressure: result held for 5 cycles with ready low.
        load_two_level_trie();
        result_ready_in = 1'b0;
        name_q   = '{16'h7B7D, 16'h2121};
        exp_sel  = '{0, 1};
        exp_addr = '{16'd0, 16'd1};
        exp_cont = '{16'h7B7D, 16'h2121};
        run_name("bp", 1'b1, 2, 16'd5, 1'b0);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            check_eq("bp_valid", 32'(result_valid_out),   32'd1);
            check_eq("bp_hit",   32'(result_hit_out),     32'd1);
            check_eq("bp_depth", 32'(result_depth_out),   32'd2);
            check_eq("bp_ptr",   32'(result_pointer_out), 32'd5);
            check_eq("bp_ready", 32'(name_ready_out),     32'd0);
            check_eq("bp_busy",  32'(busy_out),           32'd1);
        end
        result_ready_in = 1'b1;
        @(posedge clk); #1;
        check_eq("bp_release_valid", 32'(result_valid_out), 32'd0);
        check_eq("bp_release_ready", 32'(name_ready_out),   32'd1);

        // Reset during WAIT abandons the name.
        send_word(16'h7B7D, 1'b0);
        @(posedge clk); #1;
        check_eq("wait_busy",  32'(busy_out),        32'd1);
        check_eq("wait_ready", 32'(name_ready_out),  32'd0);
        check_eq("wait_cont",  32'(lookup_cont_out), 32'h7B7D);
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("rst_wait");
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        check_eq("rst_wait_ready", 32'(name_ready_out), 32'd1);
        check_eq("rst_wait_busy",  32'(busy_out),       32'd0);
        check_eq("rst_wait_rv",    32'(result_valid_out), 32'd0);

        // The next name starts again from level 0, address 0.
        name_q   = '{16'h7B7D, 16'h2121};
        exp_sel  = '{0, 1};
        exp_addr = '{16'd0, 16'd1};
        exp_cont = '{16'h7B7D, 16'h2121};
        run_name("after_rst", 1'b1, 2, 16'd5, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
